// File: rtl/mem_1r1w_masked_48x64_port.sv
// rtl/mem_1r1w_masked_48x64_port.sv - request-side port controller for the 48x64 byte-masked 1R1W SRAM
// Drives the macro W0/R0 ports, absorbs the 1-cycle read latency in a 3-entry response FIFO.
module mem_1r1w_masked_48x64_port #(
  parameter int DEPTH  = 48,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  output logic              wr_oob,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              rd_resp_err,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data,
  output logic [MASK_W-1:0] W0_mask,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data
);
  localparam int BYTE_W = DATA_W / MASK_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic              ready_q;
  logic              wr_fire, wr_in_range;
  logic              rd_fire, rd_in_range;
  logic              inf_valid, inf_err, inf_collide;
  logic [DATA_W-1:0] fwd_data;
  logic [MASK_W-1:0] fwd_mask;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] fifo_data [3];
  logic [2:0]        fifo_err;
  logic [1:0]        wr_ptr, rd_ptr, count;
  logic [2:0]        outstanding;
  logic              push, pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  assign wr_ready    = ready_q;
  assign wr_fire     = wr_valid & ready_q;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;

  assign W0_en   = wr_fire & wr_in_range;
  assign W0_addr = wr_addr;
  assign W0_data = wr_data;
  assign W0_mask = wr_mask;

  // Reads are admitted only while the in-flight slot plus buffered entries leave room.
  assign outstanding  = {2'b00, inf_valid} + {1'b0, count};
  assign rd_req_ready = ready_q & (outstanding < 3'd3);
  assign rd_fire      = rd_req_valid & rd_req_ready;
  assign rd_in_range  = {1'b0, rd_req_addr} < DEPTH_C;

  assign R0_en   = rd_fire & rd_in_range;
  assign R0_addr = rd_req_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_oob      <= 1'b0;
      inf_valid   <= 1'b0;
      inf_err     <= 1'b0;
      inf_collide <= 1'b0;
      fwd_data    <= '0;
      fwd_mask    <= '0;
    end else begin
      wr_oob      <= wr_fire & ~wr_in_range;
      inf_valid   <= rd_fire;
      inf_err     <= rd_fire & ~rd_in_range;
      inf_collide <= W0_en & R0_en & (wr_addr == rd_req_addr);
      fwd_data    <= wr_data;
      fwd_mask    <= wr_mask;
    end
  end

  // Same-cycle write bytes override the macro's pre-write read data.
  always_comb begin
    cap_data = '0;
    if (!inf_err) begin
      for (int i = 0; i < MASK_W; i++) begin
        cap_data[i*BYTE_W +: BYTE_W] = (inf_collide && fwd_mask[i]) ?
                                       fwd_data[i*BYTE_W +: BYTE_W] :
                                       R0_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign push = inf_valid;
  assign pop  = (count != 2'd0) & rd_resp_ready;

  always_ff @(posedge clock) begin
    if (push) fifo_data[wr_ptr] <= cap_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 2'd0;
      fifo_err <= '0;
    end else begin
      if (push) begin
        fifo_err[wr_ptr] <= inf_err;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_resp_valid = (count != 2'd0);
  assign rd_resp_data  = rd_resp_valid ? fifo_data[rd_ptr] : '0;
  assign rd_resp_err   = rd_resp_valid & fifo_err[rd_ptr];
endmodule

// File: tb/tb_mem_1r1w_masked_48x64_port.sv
// tb/tb_mem_1r1w_masked_48x64_port.sv - self-checking bench with SRAM macro model and reference model
module tb_mem_1r1w_masked_48x64_port;
  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid, wr_ready, wr_oob;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic        rd_req_valid, rd_req_ready;
  logic [5:0]  rd_req_addr;
  logic        rd_resp_valid, rd_resp_ready, rd_resp_err;
  logic [63:0] rd_resp_data;
  logic [5:0]  W0_addr, R0_addr;
  logic        W0_en, R0_en;
  logic [63:0] W0_data, R0_data;
  logic [7:0]  W0_mask;

  mem_1r1w_masked_48x64_port dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_oob(wr_oob),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
  );

  always #5 clock = ~clock;

  // Macro model: read returns the pre-write word one cycle after R0_en.
  logic [63:0] sram [0:63];
  always @(posedge clock) begin
    if (R0_en) R0_data <= sram[R0_addr];
    if (W0_en)
      for (int b = 0; b < 8; b++)
        if (W0_mask[b]) sram[W0_addr][b*8 +: 8] <= W0_data[b*8 +: 8];
  end

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic [63:0] ref_mem [0:47];
  exp_t        expq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pop_count = 0;
  logic        rdy_m = 1'b0;
  logic        oob_m = 1'b0;
  logic        last_rd_fire = 1'b0;
  logic [63:0] last_resp_data = '0;
  logic        last_resp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    exp_t        e;
    logic        wf, rf, ev;
    @(negedge clock);
    if (reset) begin
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_rd_req_ready", 64'(rd_req_ready), 64'd0);
      chk("rst_rd_resp_valid", 64'(rd_resp_valid), 64'd0);
      chk("rst_rd_resp_data", rd_resp_data, 64'd0);
      chk("rst_rd_resp_err", 64'(rd_resp_err), 64'd0);
      chk("rst_wr_oob", 64'(wr_oob), 64'd0);
      chk("rst_W0_en", 64'(W0_en), 64'd0);
      chk("rst_R0_en", 64'(R0_en), 64'd0);
      expq.delete();
      oob_m = 1'b0;
      last_rd_fire = 1'b0;
    end else begin
      wf = wr_valid && rdy_m;
      rf = rd_req_valid && rdy_m && (expq.size() < 3);
      chk("wr_ready", 64'(wr_ready), 64'(rdy_m));
      chk("rd_req_ready", 64'(rd_req_ready), 64'(rdy_m && (expq.size() < 3)));
      chk("wr_oob", 64'(wr_oob), 64'(oob_m));
      chk("W0_en", 64'(W0_en), 64'(wf && wr_addr < 48));
      if (wf && wr_addr < 48) begin
        chk("W0_addr", 64'(W0_addr), 64'(wr_addr));
        chk("W0_data", W0_data, wr_data);
        chk("W0_mask", 64'(W0_mask), 64'(wr_mask));
      end
      chk("R0_en", 64'(R0_en), 64'(rf && rd_req_addr < 48));
      if (rf && rd_req_addr < 48) chk("R0_addr", 64'(R0_addr), 64'(rd_req_addr));
      ev = (expq.size() > 0) && (expq[0].cyc + 2 <= cyc);
      chk("rd_resp_valid", 64'(rd_resp_valid), 64'(ev));
      if (ev) begin
        chk("rd_resp_data", rd_resp_data, expq[0].data);
        chk("rd_resp_err", 64'(rd_resp_err), 64'(expq[0].err));
        if (rd_resp_ready) begin
          last_resp_data = rd_resp_data;
          last_resp_err  = rd_resp_err;
          pop_count++;
          void'(expq.pop_front());
        end
      end
      if (rf) begin
        e.cyc = cyc;
        if (rd_req_addr >= 48) begin
          e.data = '0;
          e.err  = 1'b1;
        end else begin
          e.data = ref_mem[rd_req_addr];
          e.err  = 1'b0;
          if (wf && wr_addr == rd_req_addr)
            for (int b = 0; b < 8; b++)
              if (wr_mask[b]) e.data[b*8 +: 8] = wr_data[b*8 +: 8];
        end
        expq.push_back(e);
      end
      if (wf && wr_addr < 48)
        for (int b = 0; b < 8; b++)
          if (wr_mask[b]) ref_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
      oob_m = wf && (wr_addr >= 48);
      last_rd_fire = rf;
    end
    @(posedge clock);
    rdy_m = !reset;
    cyc++;
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    rd_resp_ready = 1'b1;
    for (int k = 0; k < 20 && expq.size() > 0; k++) tick();
    chk("drain_timeout", 64'(expq.size()), 64'd0);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a);
    rd_req_valid = 1'b1; rd_req_addr = a;
    tick();
    rd_req_valid = 1'b0;
  endtask

  initial begin
    int i;
    int p0;
    reset = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_resp_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    for (int a = 0; a < 48; a++) do_write(6'(a), {$urandom, $urandom}, 8'hFF);

    do_write(6'd5, 64'h0123456789ABCDEF, 8'hFF);
    do_read(6'd5);
    drain();
    chk("tp_full_write", last_resp_data, 64'h0123456789ABCDEF);

    do_write(6'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    do_read(6'd5);
    drain();
    chk("tp_partial_write", last_resp_data, 64'h01234567FFFFFFFF);

    do_write(6'd7, 64'h1111111111111111, 8'hFF);
    wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 64'hAAAAAAAAAAAAAAAA; wr_mask = 8'hF0;
    rd_req_valid = 1'b1; rd_req_addr = 6'd7;
    tick();
    idle();
    drain();
    chk("tp_collision", last_resp_data, 64'hAAAAAAAA11111111);

    do_read(6'd7);
    do_write(6'd7, 64'h2222222222222222, 8'hFF);
    drain();
    chk("tp_read_then_write", last_resp_data, 64'hAAAAAAAA11111111);

    do_write(6'd50, 64'hDEADBEEFDEADBEEF, 8'hFF);
    tick();
    do_read(6'd63);
    drain();
    chk("tp_oob_err", 64'(last_resp_err), 64'd1);
    chk("tp_oob_data", last_resp_data, 64'd0);

    rd_resp_ready = 1'b0;
    i = 0;
    for (int c = 0; c < 8; c++) begin
      rd_req_valid = (i < 10); rd_req_addr = 6'(i);
      tick();
      if (last_rd_fire) i++;
    end
    chk("stall_accepted", 64'(i), 64'd3);
    rd_resp_ready = 1'b1;
    p0 = pop_count;
    for (int c = 0; c < 10; c++) begin
      rd_req_valid = (i < 10); rd_req_addr = 6'(i);
      tick();
      if (last_rd_fire) i++;
    end
    chk("stream_issued", 64'(i), 64'd10);
    chk("stream_back_to_back", 64'(pop_count - p0), 64'd10);
    drain();

    for (int k = 0; k < 400; k++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 6'($urandom_range(0, 55));
      wr_data  = {$urandom, $urandom};
      wr_mask  = 8'($urandom);
      rd_req_valid = 1'($urandom_range(0, 1));
      rd_req_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 63));
      rd_resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    rd_resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) do_read(6'(10 + k));
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rd_resp_ready = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) do_read(6'(10 + k));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
